// File: rtl/fft_bitrev_framer.sv
// Double-banked frame buffer: captures natural-order complex samples and
// replays each completed frame in bit-reversed order for an FFT stage.
module fft_bitrev_framer #(
  parameter int DATA_W   = 16,
  parameter int LOG2_LEN = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_real,
  input  logic signed [DATA_W-1:0] in_imag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_real,
  output logic signed [DATA_W-1:0] out_imag,
  output logic                     out_first,
  output logic                     out_last,
  output logic [7:0]               frame_cnt
);

  localparam int FRAME_LEN = 2 ** LOG2_LEN;
  localparam int SW        = 2 * DATA_W;

  typedef logic [LOG2_LEN-1:0] idx_t;

  localparam idx_t LAST = idx_t'(FRAME_LEN - 1);

  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  idx_t       wr_idx_q, wr_idx_d;
  idx_t       rd_idx_q, rd_idx_d;
  logic [1:0] full_q, full_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;

  logic [SW-1:0] mem_q [2][FRAME_LEN];

  logic          valid;
  logic          in_fire;
  logic          out_fire;
  logic          wr_wrap;
  logic          rd_wrap;
  idx_t          rd_addr;
  logic [SW-1:0] rd_word;

  function automatic idx_t bitrev(input idx_t i);
    idx_t r;
    for (int b = 0; b < LOG2_LEN; b++) begin
      r[b] = i[LOG2_LEN-1-b];
    end
    return r;
  endfunction

  // Handshake qualifiers; reset masks both sides immediately.
  always_comb begin
    valid    = full_q[rd_bank_q] && !rst;
    in_ready = !full_q[wr_bank_q] && !rst;
    in_fire  = in_valid && in_ready;
    out_fire = valid && out_ready;
    wr_wrap  = in_fire && (wr_idx_q == LAST);
    rd_wrap  = out_fire && (rd_idx_q == LAST);
    rd_addr  = bitrev(rd_idx_q);
    rd_word  = mem_q[rd_bank_q][rd_addr];
  end

  always_comb begin
    out_valid = valid;
    out_first = valid && (rd_idx_q == '0);
    out_last  = valid && (rd_idx_q == LAST);
    out_real  = valid ? rd_word[SW-1 -: DATA_W] : '0;
    out_imag  = valid ? rd_word[DATA_W-1:0] : '0;
    frame_cnt = frame_cnt_q;
  end

  always_comb begin
    wr_bank_d   = wr_bank_q;
    wr_idx_d    = wr_idx_q;
    rd_bank_d   = rd_bank_q;
    rd_idx_d    = rd_idx_q;
    full_d      = full_q;
    frame_cnt_d = frame_cnt_q;
    if (in_fire) begin
      wr_idx_d = wr_idx_q + 1'b1;
    end
    if (wr_wrap) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = !wr_bank_q;
      wr_idx_d          = '0;
    end
    if (out_fire) begin
      rd_idx_d = rd_idx_q + 1'b1;
    end
    // The draining bank is full, the filling one is not: never the same bank.
    if (rd_wrap) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
      rd_idx_d          = '0;
      frame_cnt_d       = frame_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      rd_bank_q   <= 1'b0;
      rd_idx_q    <= '0;
      full_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      wr_idx_q    <= wr_idx_d;
      rd_bank_q   <= rd_bank_d;
      rd_idx_q    <= rd_idx_d;
      full_q      <= full_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem_q[wr_bank_q][wr_idx_q] <= {in_real, in_imag};
    end
  end

endmodule

// File: tb/tb_fft_bitrev_framer.sv
// Randomised bench for fft_bitrev_framer against a frame-queue model
// that reorders whole frames arithmetically.
module tb_fft_bitrev_framer;

  localparam int W = 16;
  localparam int L = 4;
  localparam int N = 16;
  localparam int B = 2 * W + 12;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic signed [W-1:0] in_real = '0;
  logic signed [W-1:0] in_imag = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic signed [W-1:0] out_real;
  logic signed [W-1:0] out_imag;
  logic                out_first;
  logic                out_last;
  logic [7:0]          frame_cnt;

  always #5 clk = ~clk;

  fft_bitrev_framer #(.DATA_W(W), .LOG2_LEN(L)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_real(in_real), .in_imag(in_imag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_real(out_real), .out_imag(out_imag),
    .out_first(out_first), .out_last(out_last),
    .frame_cnt(frame_cnt)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: queue of expected output words, in emission order.
  logic [2*W-1:0] exp_q [$];
  logic [2*W-1:0] part [N];
  int fill        = 0;
  int full_frames = 0;
  int out_pos     = 0;
  int frames_done = 0;

  logic [B-1:0] obs;
  logic [B-1:0] expv;

  int ord [N] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  function automatic int rev(input int i);
    int r = 0;
    for (int b = 0; b < L; b++) r = r * 2 + ((i >> b) & 1);
    return r;
  endfunction

  function automatic int obs_re();
    logic signed [W-1:0] v;
    v = obs[2*W+7:W+8];
    return int'(v);
  endfunction

  // One clock: drive, sample both DUT and model mid-cycle, then advance.
  task automatic tick(input logic iv, input logic ordy,
                      input logic [W-1:0] re, input logic [W-1:0] im);
    logic eir, eov, ifire, ofire;
    logic [2*W-1:0] ed;
    in_valid  = iv;
    out_ready = ordy;
    in_real   = re;
    in_imag   = im;
    @(negedge clk);
    obs = {in_ready, out_valid, out_first, out_last,
           out_real, out_imag, frame_cnt};
    eir = !rst && full_frames < 2;
    eov = !rst && full_frames > 0;
    ed  = (eov && exp_q.size() > 0) ? exp_q[0] : '0;
    expv = {eir, eov, eov && out_pos == 0, eov && out_pos == N - 1,
            ed, 8'(frames_done % 256)};
    ifire = iv && eir;
    ofire = eov && ordy;
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      fill = 0; full_frames = 0; out_pos = 0; frames_done = 0;
    end else begin
      if (ofire) begin
        void'(exp_q.pop_front());
        out_pos++;
        if (out_pos == N) begin
          out_pos = 0; full_frames--; frames_done++;
        end
      end
      if (ifire) begin
        part[fill] = {re, im};
        fill++;
        if (fill == N) begin
          for (int i = 0; i < N; i++) exp_q.push_back(part[rev(i)]);
          fill = 0;
          full_frames++;
        end
      end
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick(0, 0, '0, '0);
    tick(0, 0, '0, '0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick(0, 0, '0, '0);
      n_cmp++;
      if (obs[B-1:8] !== expv[B-1:8]) begin
        n_fail++;
        $display("FAIL reset_hold c=%0d got=%h exp=%h", c, obs, expv);
      end
    end
    rst = 1'b0;
    tick(0, 0, '0, '0);
    n_cmp++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL reset_release got=%h exp=%h", obs, expv);
    end
  endtask

  task automatic test_single_frame();
    int k = 0, got [$], c_acc = -1, c_ov = -1;
    reset_dut();
    for (int c = 0; c < 60 && got.size() < N; c++) begin
      logic iv;
      iv = k < N;
      tick(iv, 1, W'(k), W'(-k));
      n_cmp++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL single c=%0d got=%h exp=%h", c, obs, expv);
      end
      if (obs[B-2] && c_ov < 0) c_ov = c;
      if (obs[B-2]) got.push_back(obs_re());
      if (iv && obs[B-1]) begin
        k++;
        if (k == N) c_acc = c;
      end
    end
    n_cmp++;
    if (c_ov !== c_acc + 1) begin
      n_fail++;
      $display("FAIL single_latency got=%0d exp=%0d", c_ov, c_acc + 1);
    end
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (i >= got.size() || got[i] !== ord[i]) begin
        n_fail++;
        $display("FAIL single_order i=%0d got=%0d exp=%0d", i,
                 (i < got.size()) ? got[i] : -1, ord[i]);
      end
    end
    tick(0, 0, '0, '0);
    n_cmp++;
    if (obs[7:0] !== 8'd1) begin
      n_fail++;
      $display("FAIL single_frame_cnt got=%0d exp=1", obs[7:0]);
    end
  endtask

  task automatic test_backpressure_and_drain();
    int k = 0, acc = 0, got [$], c_last = -1, c_rise = -1;
    reset_dut();
    for (int c = 0; c < 40; c++) begin
      tick(1, 0, W'(k), W'(-k));
      n_cmp++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL bp c=%0d got=%h exp=%h", c, obs, expv);
      end
      if (obs[B-2] && obs_re() != 0) begin
        n_fail++;
        $display("FAIL bp_hold c=%0d got=%0d exp=0", c, obs_re());
      end
      if (obs[B-1]) begin
        acc++; k++;
      end
    end
    n_cmp++;
    if (acc !== 32 || obs[B-1] !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_accepted got=%0d/%b exp=32/0", acc, obs[B-1]);
    end
    for (int c = 0; c < 80 && got.size() < 2 * N; c++) begin
      tick(0, 1, '0, '0);
      n_cmp++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL drain c=%0d got=%h exp=%h", c, obs, expv);
      end
      if (obs[B-1] && c_rise < 0) c_rise = c;
      if (obs[B-2] && obs[B-4] && c_last < 0) c_last = c;
      if (obs[B-2]) got.push_back(obs_re());
    end
    n_cmp++;
    if (c_rise !== c_last + 1) begin
      n_fail++;
      $display("FAIL drain_ready_rise got=%0d exp=%0d", c_rise, c_last + 1);
    end
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (N + i >= got.size() || got[N+i] !== 16 + ord[i]) begin
        n_fail++;
        $display("FAIL drain_order i=%0d exp=%0d", i, 16 + ord[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int drops = 0, c = 0;
    reset_dut();
    while (frames_done < 300 && c < 6000) begin
      logic [W-1:0] d;
      d = W'($urandom);
      tick(1, 1, d, ~d);
      n_cmp++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL stream c=%0d got=%h exp=%h", c, obs, expv);
      end
      if (!obs[B-1]) drops++;
      c++;
    end
    tick(0, 0, '0, '0);
    n_cmp++;
    if (drops !== 0 || obs[7:0] !== 8'd44) begin
      n_fail++;
      $display("FAIL stream_wrap drops=%0d cnt=%0d exp=0/44", drops, obs[7:0]);
    end
  endtask

  task automatic test_reset_mid_frame();
    int k = 0, c = 0, first_re = -1;
    reset_dut();
    for (int i = 0; i < 10; i++) tick(1, 1, W'(i), W'(i));
    reset_dut();
    while (first_re < 0 && c < 60) begin
      logic iv;
      iv = k < N;
      tick(iv, 1, W'(100 + k), W'(k));
      n_cmp++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL midrst c=%0d got=%h exp=%h", c, obs, expv);
      end
      if (obs[B-2]) first_re = obs_re();
      if (iv && obs[B-1]) k++;
      c++;
    end
    n_cmp++;
    if (first_re !== 100 || c !== 17) begin
      n_fail++;
      $display("FAIL midrst_first got=%0d@%0d exp=100@17", first_re, c);
    end
  endtask

  task automatic test_random();
    int c = 0;
    reset_dut();
    while (frames_done < 1000 && c < 70000) begin
      tick($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           W'($urandom), W'($urandom));
      n_cmp++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL random c=%0d got=%h exp=%h", c, obs, expv);
      end
      c++;
    end
    tick(0, 0, '0, '0);
    n_cmp++;
    if (obs[7:0] !== 8'd232) begin
      n_fail++;
      $display("FAIL random_frames cnt=%0d exp=232 cycles=%0d", obs[7:0], c);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_single_frame();
    test_backpressure_and_drain();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
